tx_fifo_feeder: RTL and testbench
=================================

TX_FIFO_FEEDER -- requirements
Module: tx_fifo_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter DW, default 8, data width in bits.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port wr_en  input  1  write strobe for one byte per cycle.
REQ-006 SHALL have port wr_data  input  DW  byte to enqueue.
REQ-007 SHALL have port flush  input  1  discard all queued bytes.
REQ-008 SHALL have port tx_busy  input  1  busy flag from the UART transmitter.
REQ-009 SHALL have port tx_data  output  DW  byte presented to the transmitter's data input.
REQ-010 SHALL have port tx_start  output  1  start request to the transmitter's start input.
REQ-011 SHALL have port full, empty  output  1 each  FIFO status.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port overflow  output  1  sticky write-while-full flag.

Function
REQ-014 SHALL accept a write iff wr_en=1, full=0 and flush=0; the byte is visible (empty=0) the cycle after the accepting edge, with no bypass path.
REQ-015 SHALL set overflow when wr_en=1 and full=1 with flush=0; the byte is dropped and overflow holds until rst or flush.
REQ-016 SHALL implement FSM states IDLE, START, WAIT_DONE.
REQ-017 In IDLE with empty=0 and tx_busy=0, SHALL pop the head into the tx_data register and go to START at the same edge.
REQ-018 In START, SHALL drive tx_start=1 and stay there until tx_busy=1 is sampled, then go to WAIT_DONE.
REQ-019 In WAIT_DONE, SHALL drive tx_start=0 and return to IDLE when tx_busy=0 is sampled.
REQ-020 SHALL hold tx_data stable from the pop edge until the next pop.
REQ-021 Latency: a write accepted at edge N into an empty FIFO with FSM IDLE and tx_busy=0 SHALL produce tx_start=1 after edge N+1.
REQ-022 A write and a pop at the same edge SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-023 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both registered-consistent with count every cycle.
REQ-024 flush SHALL zero pointers and count, and clear overflow at the next edge; it SHALL NOT alter FSM state, tx_data or the in-flight handshake.
REQ-025 flush with wr_en in the same cycle SHALL drop the write without setting overflow.
REQ-026 SHALL not pop while in START or WAIT_DONE, even if empty=0.

Reset
REQ-027 On rst=1 at an edge: FSM=IDLE, tx_start=0, tx_data=0, count=0, empty=1, full=0, overflow=0, pointers=0.
REQ-028 rst SHALL abort any handshake mid-operation; queued bytes are lost; rst takes priority over flush and wr_en.

Structure
REQ-029 The state enum and default DEPTH/DW constants SHALL reside in the shared package uart_pkg.
REQ-030 Storage SHALL be the sub-module sync_fifo (pointers, count, full/empty, overflow); tx_fifo_feeder holds the FSM and tx_data register.
REQ-031 Storage SHALL be a register array with no reset on data contents.

Verification
REQ-032 Single byte: write 0xA5 into an empty FIFO with tx_busy=0 -> tx_start rises after edge N+1 with tx_data=0xA5; model raises tx_busy 3 cycles later -> tx_start falls; tx_busy low -> FSM returns to IDLE.
REQ-033 Fill: 17 back-to-back writes 0x00..0x10 with tx_busy held 1 -> the first byte pops; the remaining 16 fill the FIFO, full=1, count=16, overflow=0; one further write 0x11 -> overflow=1 and 0x11 never appears on tx_data.
REQ-034 Drain order: queue 0x11,0x22,0x33; the transmitter model pulses busy for 10 cycles per start -> tx_data sequence 0x11,0x22,0x33, then empty=1, count=0.
REQ-035 Simultaneous: count=5, wr_en at the pop edge -> count stays 5; pointer wrap verified over 40 bytes with no data loss.
REQ-036 Flush in WAIT_DONE with count=4 and overflow=1 -> count=0, overflow=0, tx_data unchanged, handshake completes normally; flush+wr_en in the same cycle -> count=0.
REQ-037 rst asserted in START -> next cycle tx_start=0, empty=1, tx_data=0x00.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and default sizing for the UART transmit path
package uart_pkg;
    localparam int DEPTH_DEF = 16;
    localparam int DW_DEF = 8;
    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;
endpackage

// File: rtl/tx_fifo_feeder_if.sv
// tx_fifo_feeder_if: write side, transmitter handshake and FIFO status of the feeder
interface tx_fifo_feeder_if import uart_pkg::*; #(parameter int DEPTH = DEPTH_DEF, parameter int DW = DW_DEF);
    logic wr_en, flush, tx_busy, tx_start, full, empty, overflow;
    logic [DW-1:0] wr_data, tx_data;
    logic [$clog2(DEPTH):0] count;
    modport master (output wr_en, wr_data, flush, tx_busy, input tx_data, tx_start, full, empty, count, overflow);
    modport slave (input wr_en, wr_data, flush, tx_busy, output tx_data, tx_start, full, empty, count, overflow);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: register-array FIFO with occupancy count and sticky overflow flag
module sync_fifo import uart_pkg::*; #(parameter int DEPTH = DEPTH_DEF, parameter int DW = DW_DEF) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     flush,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_wr, do_rd;
    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty && !flush;
    assign rd_data = mem[rp];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk)
        if (do_wr) mem[wp] <= wr_data;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
            if (wr_en && full) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/tx_fifo_feeder.sv
// tx_fifo_feeder: queues bytes and hands them one at a time to a UART transmitter
module tx_fifo_feeder import uart_pkg::*; #(parameter int DEPTH = DEPTH_DEF, parameter int DW = DW_DEF) (
    input logic             clk,
    input logic             rst,
    tx_fifo_feeder_if.slave bus
);
    state_t state, nxt;
    logic pop;
    logic [DW-1:0] head, tx_q;
    sync_fifo #(.DEPTH(DEPTH), .DW(DW)) fifo (
        .clk(clk), .rst(rst), .wr_en(bus.wr_en), .wr_data(bus.wr_data), .flush(bus.flush),
        .rd_en(pop), .rd_data(head), .full(bus.full), .empty(bus.empty),
        .count(bus.count), .overflow(bus.overflow)
    );
    // a flushing cycle discards the queue, so nothing is popped from it
    always_comb begin
        pop = state == IDLE && !bus.empty && !bus.tx_busy && !bus.flush;
        nxt = pop ? START :
              (state == START && bus.tx_busy) ? WAIT_DONE :
              (state == WAIT_DONE && !bus.tx_busy) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tx_q <= '0;
        end else begin
            state <= nxt;
            if (pop) tx_q <= head;
        end
    end
    assign bus.tx_data = tx_q;
    assign bus.tx_start = state == START;
endmodule

// File: tb/tb_tx_fifo_feeder.sv
// tb_tx_fifo_feeder: randomized scoreboard bench with a queue-level reference model
module tb_tx_fifo_feeder;
    import uart_pkg::*;
    localparam int DEPTH = 16;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    tx_fifo_feeder_if #(.DEPTH(DEPTH), .DW(DW)) bus ();
    tx_fifo_feeder #(.DEPTH(DEPTH), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    bit m_ovf;
    int m_ph;
    logic [7:0] m_txd;
    bit auto_tx;
    int t_wait = -1;
    int t_hold = 0;
    int t_dly = 1;
    int t_len = 1;
    bit prev_start = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // m_ph: 0 = no byte in flight, 1 = start requested, 2 = transmitter busy with it
    task automatic model_edge();
        bit was_full, do_pop;
        if (rst) begin
            mq.delete();
            sb.delete();
            m_ovf = 0;
            m_ph = 0;
            m_txd = 0;
            return;
        end
        was_full = mq.size() == DEPTH;
        do_pop = m_ph == 0 && mq.size() > 0 && !bus.tx_busy && !bus.flush;
        if (do_pop) begin
            m_txd = mq.pop_front();
            sb.push_back(m_txd);
        end
        if (bus.flush) begin
            mq.delete();
            m_ovf = 0;
        end else if (bus.wr_en) begin
            if (was_full) m_ovf = 1;
            else mq.push_back(bus.wr_data);
        end
        m_ph = do_pop ? 1 : (m_ph == 1 && bus.tx_busy) ? 2 : (m_ph == 2 && !bus.tx_busy) ? 0 : m_ph;
    endtask

    task automatic check_all();
        chk("count", bus.count, mq.size());
        chk("full", bus.full, mq.size() == DEPTH);
        chk("empty", bus.empty, mq.size() == 0);
        chk("overflow", bus.overflow, m_ovf);
        chk("tx_start", bus.tx_start, m_ph == 1);
        chk("tx_data", bus.tx_data, m_txd);
    endtask

    // transmitter model: raises busy t_dly cycles after seeing start, holds it t_len cycles
    task automatic xmtr();
        if (rst) begin
            t_wait = -1;
            t_hold = 0;
            if (auto_tx) bus.tx_busy = 1'b0;
            return;
        end
        if (!auto_tx) return;
        if (bus.tx_busy) begin
            t_hold--;
            if (t_hold <= 0) bus.tx_busy = 1'b0;
        end else if (t_wait > 0) begin
            t_wait--;
            if (t_wait == 0) begin
                bus.tx_busy = 1'b1;
                t_hold = t_len;
                t_wait = -1;
            end
        end else if (bus.tx_start) t_wait = t_dly;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        xmtr();
    endtask

    task automatic set_in(input bit w, input logic [7:0] d, input bit f);
        bus.wr_en = w;
        bus.wr_data = d;
        bus.flush = f;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (!(mq.size() == 0 && m_ph == 0 && !bus.tx_busy && t_wait < 0) && n < max) begin
            step();
            n++;
        end
        if (n >= max) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: count %0d still queued after %0d cycles", mq.size(), n);
        end
    endtask

    always @(negedge clk) begin
        if (bus.tx_start === 1'b1 && !prev_start) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL tx_byte: start with data %02h but no byte expected", bus.tx_data);
            end else chk("tx_byte", bus.tx_data, sb.pop_front());
        end
        prev_start = bus.tx_start === 1'b1;
    end

    initial begin
        logic [7:0] seq [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] held;
        int written, n;
        bit w;
        rst = 1'b1;
        set_in(0, 8'h00, 0);
        bus.tx_busy = 1'b0;
        auto_tx = 0;
        step();
        step();
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        rst = 1'b0;
        // single byte with the transmitter answering three cycles after start
        auto_tx = 1;
        t_dly = 3;
        t_len = 4;
        set_in(1, 8'hA5, 0);
        step();
        set_in(0, 8'h00, 0);
        chk("lat_empty", bus.empty, 0);
        step();
        chk("lat_start", bus.tx_start, 1);
        chk("lat_data", bus.tx_data, 8'hA5);
        drain(100);
        // fill to full behind a busy transmitter, then overflow with 0x11
        auto_tx = 0;
        bus.tx_busy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_in(1, 8'(i), 0);
            step();
            if (i == 1) bus.tx_busy = 1'b1;
        end
        set_in(0, 8'h00, 0);
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 16);
        chk("fill_no_ovf", bus.overflow, 0);
        set_in(1, 8'h11, 0);
        step();
        set_in(0, 8'h00, 0);
        chk("fill_ovf", bus.overflow, 1);
        chk("fill_count_hold", bus.count, 16);
        auto_tx = 1;
        t_dly = 2;
        t_len = 3;
        drain(1000);
        chk("ovf_sticky", bus.overflow, 1);
        set_in(0, 8'h00, 1);
        step();
        set_in(0, 8'h00, 0);
        // drain order with ten-cycle busy pulses
        t_dly = 1;
        t_len = 10;
        foreach (seq[i]) begin
            set_in(1, seq[i], 0);
            step();
        end
        set_in(0, 8'h00, 0);
        drain(500);
        chk("order_empty", bus.empty, 1);
        chk("order_count", bus.count, 0);
        // write and pop on the same edge
        auto_tx = 0;
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1, 8'(8'h50 + i), 0);
            step();
        end
        chk("simul_pre", bus.count, 5);
        bus.tx_busy = 1'b0;
        set_in(1, 8'h5A, 0);
        step();
        set_in(0, 8'h00, 0);
        chk("simul_count", bus.count, 5);
        chk("simul_start", bus.tx_start, 1);
        // pointer wrap over 40 bytes
        auto_tx = 1;
        written = 0;
        n = 0;
        while (written < 40 && n < 2000) begin
            t_dly = $urandom_range(1, 4);
            t_len = $urandom_range(1, 6);
            w = $urandom_range(0, 1) == 1 && mq.size() < DEPTH;
            set_in(w, 8'($urandom), 0);
            step();
            if (w) written++;
            n++;
        end
        set_in(0, 8'h00, 0);
        drain(2000);
        // flush while the transmitter is busy with a byte, count=4 and overflow set
        auto_tx = 0;
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_in(1, 8'(8'hC0 + i), 0);
            step();
        end
        set_in(0, 8'h00, 0);
        auto_tx = 1;
        t_dly = 1;
        t_len = 3;
        n = 0;
        while (!(mq.size() == 4 && m_ph == 2) && n < 1000) begin
            step();
            n++;
        end
        chk("reach_wait_done", n < 1000, 1);
        auto_tx = 0;
        bus.tx_busy = 1'b1;
        held = m_txd;
        chk("pre_flush_ovf", bus.overflow, 1);
        set_in(0, 8'h00, 1);
        step();
        set_in(0, 8'h00, 0);
        chk("flush_count", bus.count, 0);
        chk("flush_ovf", bus.overflow, 0);
        chk("flush_tx_data", bus.tx_data, held);
        bus.tx_busy = 1'b0;
        step();
        step();
        chk("flush_done_start", bus.tx_start, 0);
        chk("flush_done_data", bus.tx_data, held);
        bus.tx_busy = 1'b1;
        set_in(1, 8'h71, 0);
        step();
        set_in(1, 8'h72, 0);
        step();
        set_in(1, 8'h77, 1);
        step();
        set_in(0, 8'h00, 0);
        chk("flush_wr_count", bus.count, 0);
        chk("flush_wr_ovf", bus.overflow, 0);
        bus.tx_busy = 1'b0;
        // reset while requesting start
        set_in(1, 8'h3C, 0);
        step();
        set_in(0, 8'h00, 0);
        step();
        chk("pre_rst_start", bus.tx_start, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_start_start", bus.tx_start, 0);
        chk("rst_start_empty", bus.empty, 1);
        chk("rst_start_data", bus.tx_data, 0);
        // random traffic with occasional flush and reset
        auto_tx = 1;
        for (int i = 0; i < 800; i++) begin
            t_dly = $urandom_range(1, 5);
            t_len = $urandom_range(1, 8);
            rst = $urandom_range(0, 199) == 0;
            set_in($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0;
        set_in(0, 8'h00, 0);
        drain(2000);
        chk("end_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
